// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared HUB75 scan definitions: panel geometry, timing defaults and scan state encoding.
// Imported by the scan controller, line renderer and frame-buffer writer.
package hub75_scan_ctrl_pkg;

    localparam int unsigned DEF_ROWS         = 32;
    localparam int unsigned DEF_PWM_STEPS    = 16;
    localparam int unsigned DEF_HOLD_CYCLES  = 64;
    localparam int unsigned DEF_BLANK_CYCLES = 2;
    localparam int unsigned DEF_DONE_TIMEOUT = 256;

    localparam int ADDR_W = 5;
    localparam int PWM_W  = 4;
    localparam int TMR_W  = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BEGIN,
        ST_GUARD,
        ST_RENDER,
        ST_BLANK1,
        ST_LATCH,
        ST_BLANK2,
        ST_HOLD,
        ST_NEXT
    } scan_state_t;

    // A timed state lasting n cycles loads n-1 and leaves when the timer reads zero.
    function automatic logic [TMR_W-1:0] tmr_count(input int unsigned cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Signal bundle between the scan controller and the renderer / panel / frame writer.
// master = scan controller, slave = the surrounding blocks.
interface hub75_scan_ctrl_if;
    import hub75_scan_ctrl_pkg::*;

    logic              enable;
    logic              line_begin;
    logic              line_done;
    logic [ADDR_W-1:0] line_addr;
    logic [PWM_W-1:0]  pwm;
    logic              base_addr;
    logic [ADDR_W-1:0] panel_addr;
    logic              lat;
    logic              oe_n;
    logic              swap_req;
    logic              swap_ack;
    logic              frame_start;
    logic              timeout_err;

    modport master (
        input  enable, line_done, swap_req,
        output line_begin, line_addr, pwm, base_addr, panel_addr,
               lat, oe_n, swap_ack, frame_start, timeout_err
    );

    modport slave (
        output enable, line_done, swap_req,
        input  line_begin, line_addr, pwm, base_addr, panel_addr,
               lat, oe_n, swap_ack, frame_start, timeout_err
    );
endinterface

// File: rtl/hub75_scan_ctrl_scan_timer.sv
// Loadable down-counter with zero flag; shared by the blank, hold and line_done timeout phases.
module scan_timer
    import hub75_scan_ctrl_pkg::*;
(
    input  logic             clk_25MHz,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);
    logic [TMR_W-1:0] count;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - TMR_W'(1);
    end

    assign zero = (count == '0);
endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: steps row/PWM level, hands each line to the renderer, then
// blanks, latches and lights the row. Owns the frame-buffer bank select.
//
//  state  | meaning
//  IDLE   | parked, panel dark, waiting for enable
//  BEGIN  | line_begin pulse to renderer
//  GUARD  | one cycle ignoring stale line_done
//  RENDER | waiting for line_done or timeout
//  BLANK1 | panel dark before latch
//  LATCH  | lat pulse, panel row address updated
//  BLANK2 | panel dark after latch
//  HOLD   | row lit (oe_n low)
//  NEXT   | advance pwm/row, frame-end bank swap
module hub75_scan_ctrl
    import hub75_scan_ctrl_pkg::*;
#(
    parameter int unsigned ROWS         = DEF_ROWS,
    parameter int unsigned PWM_STEPS    = DEF_PWM_STEPS,
    parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int unsigned DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input logic               clk_25MHz,
    input logic               rst_n,
    hub75_scan_ctrl_if.master bus
);
    scan_state_t       state, state_d;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;
    logic [ADDR_W-1:0] row_q, row_d, panel_q, panel_d;
    logic [PWM_W-1:0]  pwm_q, pwm_d;
    logic              base_q, base_d, begin_q, begin_d, lat_q, lat_d;
    logic              oe_n_q, oe_n_d, ack_q, ack_d, fs_q, fs_d, to_q, to_d;
    logic              pwm_last, row_last;

    assign pwm_last = (pwm_q == PWM_W'(PWM_STEPS - 1));
    assign row_last = (row_q == ADDR_W'(ROWS - 1));

    scan_timer u_timer (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .zero      (tmr_zero)
    );

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            ST_IDLE:   if (bus.enable) state_d = ST_BEGIN;
            ST_BEGIN:  state_d = ST_GUARD;
            ST_GUARD: begin
                state_d  = ST_RENDER;
                tmr_load = 1'b1;
                tmr_val  = tmr_count(DONE_TIMEOUT);
            end
            ST_RENDER: if (bus.line_done || tmr_zero) begin
                state_d  = ST_BLANK1;
                tmr_load = 1'b1;
                tmr_val  = tmr_count(BLANK_CYCLES);
            end
            ST_BLANK1: if (tmr_zero) state_d = ST_LATCH;
            ST_LATCH: begin
                state_d  = ST_BLANK2;
                tmr_load = 1'b1;
                tmr_val  = tmr_count(BLANK_CYCLES);
            end
            ST_BLANK2: if (tmr_zero) begin
                state_d  = ST_HOLD;
                tmr_load = 1'b1;
                tmr_val  = tmr_count(HOLD_CYCLES);
            end
            ST_HOLD:   if (tmr_zero) state_d = ST_NEXT;
            ST_NEXT:   state_d = bus.enable ? ST_BEGIN : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state so each pulse lines up with its state.
    always_comb begin
        pwm_d  = pwm_q;
        row_d  = row_q;
        base_d = base_q;
        ack_d  = 1'b0;
        if (state == ST_NEXT) begin
            if (pwm_last) begin
                pwm_d = '0;
                row_d = row_last ? '0 : row_q + ADDR_W'(1);
                if (row_last && bus.swap_req) begin
                    base_d = ~base_q;
                    ack_d  = 1'b1;
                end
            end else begin
                pwm_d = pwm_q + PWM_W'(1);
            end
        end
        begin_d = (state_d == ST_BEGIN);
        fs_d    = begin_d && (row_d == '0) && (pwm_d == '0);
        lat_d   = (state_d == ST_LATCH);
        panel_d = lat_d ? row_q : panel_q;
        oe_n_d  = (state_d != ST_HOLD);
        to_d    = to_q || ((state == ST_RENDER) && !bus.line_done && tmr_zero);
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            pwm_q   <= '0;
            base_q  <= 1'b0;
            panel_q <= '0;
            begin_q <= 1'b0;
            lat_q   <= 1'b0;
            oe_n_q  <= 1'b1;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            row_q   <= row_d;
            pwm_q   <= pwm_d;
            base_q  <= base_d;
            panel_q <= panel_d;
            begin_q <= begin_d;
            lat_q   <= lat_d;
            oe_n_q  <= oe_n_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
            to_q    <= to_d;
        end
    end

    assign bus.line_begin  = begin_q;
    assign bus.line_addr   = row_q;
    assign bus.pwm         = pwm_q;
    assign bus.base_addr   = base_q;
    assign bus.panel_addr  = panel_q;
    assign bus.lat         = lat_q;
    assign bus.oe_n        = oe_n_q;
    assign bus.swap_ack    = ack_q;
    assign bus.frame_start = fs_q;
    assign bus.timeout_err = to_q;
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with a small panel (4 rows, 4 PWM levels) and a
// renderer model whose done timing can be normal, absent or stuck high.
module tb_hub75_scan_ctrl;
    logic clk_25MHz = 1'b0;
    logic rst_n     = 1'b0;
    logic enable    = 1'b0;
    logic swap_req  = 1'b0;
    logic done_r;
    int   done_cnt;
    int   mode = 0;          // 0 normal renderer, 1 never done, 2 done stuck high
    int   cyc = 0;
    int   t_begin = 0;
    int   ack_cnt = 0;
    int   nvec = 0;
    int   nerr = 0;

    hub75_scan_ctrl_if bus ();

    assign bus.enable    = enable;
    assign bus.swap_req  = swap_req;
    assign bus.line_done = done_r;

    hub75_scan_ctrl #(
        .ROWS(4), .PWM_STEPS(4), .HOLD_CYCLES(8), .BLANK_CYCLES(2), .DONE_TIMEOUT(16)
    ) dut (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .bus       (bus.master)
    );

    always #5 clk_25MHz = ~clk_25MHz;

    always @(posedge clk_25MHz) cyc <= cyc + 1;

    always @(negedge clk_25MHz) if (bus.swap_ack) ack_cnt <= ack_cnt + 1;

    // Renderer: done rises so that RENDER lasts 11 cycles, giving a 27-cycle pass.
    always @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            done_r   <= 1'b0;
            done_cnt <= 0;
        end else if (mode == 2) begin
            done_r <= 1'b1;
        end else if (bus.line_begin) begin
            done_r   <= 1'b0;
            done_cnt <= (mode == 0) ? 11 : 0;
        end else if (done_cnt != 0) begin
            done_cnt <= done_cnt - 1;
            if (done_cnt == 1) done_r <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_begin(input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk_25MHz);
            if (bus.line_begin) begin
                ok = 1'b1;
                break;
            end
        end
        t_begin = cyc;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_line_begin"},  bus.line_begin, 0);
        check({tag, "_line_addr"},   bus.line_addr, 0);
        check({tag, "_pwm"},         bus.pwm, 0);
        check({tag, "_base_addr"},   bus.base_addr, 0);
        check({tag, "_panel_addr"},  bus.panel_addr, 0);
        check({tag, "_lat"},         bus.lat, 0);
        check({tag, "_oe_n"},        bus.oe_n, 1);
        check({tag, "_swap_ack"},    bus.swap_ack, 0);
        check({tag, "_frame_start"}, bus.frame_start, 0);
        check({tag, "_timeout_err"}, bus.timeout_err, 0);
    endtask

    // One scan pass, starting from the negedge before its BEGIN and ending on its NEXT cycle.
    task automatic do_pass(input int row, input int pw, input int gap, input int lat_off,
                           input bit base, input bit ack, input bit to_begin, input bit to_lat);
        bit ok;
        int prev, lows;
        prev = t_begin;
        wait_begin(60, ok);
        check("begin_seen", ok, 1);
        if (gap > 0) check("begin_period", t_begin - prev, gap);
        check("line_addr", bus.line_addr, row);
        check("pwm", bus.pwm, pw);
        check("frame_start", bus.frame_start, (row == 0 && pw == 0));
        check("base_addr", bus.base_addr, base);
        check("swap_ack", bus.swap_ack, ack);
        check("timeout_err_begin", bus.timeout_err, to_begin);
        repeat (lat_off) @(negedge clk_25MHz);
        check($sformatf("lat_at_%0d", lat_off), bus.lat, 1);
        check("panel_addr_at_lat", bus.panel_addr, row);
        check("line_addr_held", bus.line_addr, row);
        check("pwm_held", bus.pwm, pw);
        check("timeout_err_lat", bus.timeout_err, to_lat);
        @(negedge clk_25MHz);
        check("lat_width", bus.lat, 0);
        @(negedge clk_25MHz);
        check("oe_n_blank2", bus.oe_n, 1);
        lows = 0;
        repeat (8) begin
            @(negedge clk_25MHz);
            if (!bus.oe_n) lows++;
        end
        check("hold_cycles", lows, 8);
        @(negedge clk_25MHz);
        check("oe_n_next", bus.oe_n, 1);
    endtask

    initial begin
        bit ok;
        int ix, gap, lat_off;

        repeat (3) @(negedge clk_25MHz);
        check_reset_values("reset");

        rst_n  = 1'b1;
        enable = 1'b1;

        // Frames 1-3 plus the first pass of frame 4: swap pending/honoured, swap withdrawn,
        // a timed-out line and a stuck-high done.
        for (int p = 0; p < 49; p++) begin
            ix = p % 16;
            if (p == 21) swap_req = 1'b1;
            if (p == 34) swap_req = 1'b1;
            if (p == 38) swap_req = 1'b0;
            if (p == 40) mode = 1;
            if (p == 43) mode = 2;
            gap     = (p == 0) ? 0 : (p == 41) ? 32 : (p == 44) ? 17 : 27;
            lat_off = (p == 40) ? 20 : (p == 43) ? 5 : 15;
            do_pass(ix / 4, ix % 4, gap, lat_off, (p >= 32), (p == 32), (p > 40), (p >= 40));
            mode = 0;
            if (p == 31) check("no_early_ack", ack_cnt, 0);
            if (p == 32) swap_req = 1'b0;
        end
        check("ack_total", ack_cnt, 1);

        // Drop enable mid-HOLD: the step finishes, the FSM parks, then resumes in place.
        wait_begin(60, ok);
        check("pre_park_begin", ok, 1);
        check("pre_park_pwm", bus.pwm, 1);
        repeat (20) @(negedge clk_25MHz);
        check("park_in_hold", bus.oe_n, 0);
        enable = 1'b0;
        wait_begin(40, ok);
        check("parked_no_begin", ok, 0);
        check("parked_oe_n", bus.oe_n, 1);
        enable = 1'b1;
        @(negedge clk_25MHz);
        check("resume_begin", bus.line_begin, 1);
        check("resume_pwm", bus.pwm, 2);
        check("resume_row", bus.line_addr, 0);
        check("resume_base", bus.base_addr, 1);

        // Asynchronous reset in the middle of HOLD.
        repeat (20) @(negedge clk_25MHz);
        check("rst_in_hold", bus.oe_n, 0);
        check("rst_err_before", bus.timeout_err, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk_25MHz);
        rst_n = 1'b1;
        wait_begin(10, ok);
        check("restart_begin", ok, 1);
        check("restart_frame_start", bus.frame_start, 1);
        check("restart_pwm", bus.pwm, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
